cache_arbiter: RTL
==================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256: cacheline width in bits for all rdata/wdata ports.
REQ-002 SHALL have parameter ADDR_W, default 32: address width for all addr ports.
REQ-003 SHALL have port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports i_dfp_addr/i_dfp_read/i_dfp_write, input, ADDR_W/1/1: instruction-cache memory request.
REQ-006 SHALL have port i_dfp_wdata, input, LINE_W: instruction-cache writeback line.
REQ-007 SHALL have ports i_dfp_rdata/i_dfp_resp, output, LINE_W/1: instruction-cache response.
REQ-008 SHALL have ports d_dfp_addr/d_dfp_read/d_dfp_write/d_dfp_wdata, input, ADDR_W/1/1/LINE_W: data-cache memory request.
REQ-009 SHALL have ports d_dfp_rdata/d_dfp_resp, output, LINE_W/1: data-cache response.
REQ-010 SHALL have ports dfp_addr/dfp_read/dfp_write/dfp_wdata, output, ADDR_W/1/1/LINE_W: shared memory request.
REQ-011 SHALL have ports dfp_rdata/dfp_resp, input, LINE_W/1: shared memory response.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, held in a package enum.
REQ-013 SHALL treat a requester as pending when its read or write is high; read and write both high from one requester is illegal.
REQ-014 In IDLE with one pending requester, SHALL move to that requester's SERVE state on the next edge (one-cycle arbitration latency).
REQ-015 In IDLE with both pending, SHALL grant per REQ-026/REQ-027.
REQ-016 On entry to SERVE_x, SHALL capture addr, read, write, wdata of x into registers; dfp_* outputs SHALL be driven only from those registers.
REQ-017 Outside SERVE states, dfp_read and dfp_write SHALL be 0; dfp_addr and dfp_wdata are don't-care.
REQ-018 In SERVE_x, SHALL route dfp_rdata to x_dfp_rdata combinationally and assert x_dfp_resp = dfp_resp; the other requester's resp SHALL be 0.
REQ-019 In SERVE_x with dfp_resp high, SHALL return to IDLE on the next edge, giving one idle bubble between transactions.
REQ-020 Requesters SHALL hold request signals stable until their resp; dropping early is illegal.
REQ-021 A request raised by the served requester in its resp cycle SHALL be arbitrated from IDLE like any other.
REQ-022 dfp_resp while in IDLE SHALL be ignored, and neither resp output asserted.
REQ-023 The block SHALL never assert both i_dfp_resp and d_dfp_resp in one cycle.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE, dfp_read=0, dfp_write=0, i_dfp_resp=0, d_dfp_resp=0, and priority pointer = I-side, including mid-transaction.
REQ-025 After rst deasserts, the first edge SHALL perform normal IDLE arbitration; a late dfp_resp from an aborted transaction is ignored per REQ-022.

Configuration
REQ-026 With ARB_ROUND_ROBIN_EN defined, a one-bit last-served pointer SHALL grant the requester not served most recently on conflict; the pointer updates on each SERVE entry.
REQ-027 Without ARB_ROUND_ROBIN_EN, conflicts SHALL be granted to the D-side (fixed priority) and no pointer register exists.

Structure
REQ-028 SHALL place the arb_state_t enum and the arb_req_t struct (addr, read, write, wdata) in cache_types.
REQ-029 SHALL be a single module with no sub-modules; grant selection is an internal always_comb block.

Verification
REQ-030 I-only read 0x0000_1000; memory resp after 5 cycles with line 0xA5.. -> dfp_read rises 1 cycle after request, i_dfp_resp=1 with rdata 0xA5.., d_dfp_resp=0.
REQ-031 Simultaneous I read 0x100 and D write 0x200: with RR after reset -> I served first, then D; without macro -> D first; each dfp_addr matches the served requester.
REQ-032 RR mode, both held pending for 6 transactions -> grant sequence I,D,I,D,I,D, one IDLE cycle between each.
REQ-033 D write 0x0000_2000 with wdata 0xDEAD.. -> dfp_write=1, dfp_wdata=0xDEAD.. held stable until dfp_resp; d_dfp_resp pulses one cycle.
REQ-034 rst asserted mid-SERVE_D, dfp_resp pulsed 2 cycles after release -> dfp_read/write drop asynchronously, state IDLE, no resp output asserted.
REQ-035 Assertions throughout: resp outputs never both high; dfp_read and dfp_write never both high; dfp_* stable within each SERVE state.

Source files
------------

// File: rtl/cache_types.sv
// Shared types for the cache arbiter: FSM state enum and captured request struct.
// The struct widths bound the widest LINE_W/ADDR_W the arbiter can be built with.
package cache_types;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  read;
    logic                  write;
    logic [ARB_LINE_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/cache_arbiter.sv
// Two-port (I/D cache) to single memory port arbiter with one idle bubble per transaction.
// Conflict policy: fixed D priority by default; define ARB_ROUND_ROBIN_EN for round-robin.
module cache_arbiter
  import cache_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] i_dfp_addr,
  input  logic              i_dfp_read,
  input  logic              i_dfp_write,
  input  logic [LINE_W-1:0] i_dfp_wdata,
  output logic [LINE_W-1:0] i_dfp_rdata,
  output logic              i_dfp_resp,

  input  logic [ADDR_W-1:0] d_dfp_addr,
  input  logic              d_dfp_read,
  input  logic              d_dfp_write,
  input  logic [LINE_W-1:0] d_dfp_wdata,
  output logic [LINE_W-1:0] d_dfp_rdata,
  output logic              d_dfp_resp,

  output logic [ADDR_W-1:0] dfp_addr,
  output logic              dfp_read,
  output logic              dfp_write,
  output logic [LINE_W-1:0] dfp_wdata,
  input  logic [LINE_W-1:0] dfp_rdata,
  input  logic              dfp_resp
);

  arb_state_t r_state;
  arb_state_t w_next;
  arb_req_t   r_req;
  arb_req_t   w_req_sel;
  logic       w_i_pend;
  logic       w_d_pend;
  logic       w_grant_d;
  logic       w_enter;
  logic       w_serving;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = I-side wins the next conflict; after reset the I side goes first.
  logic       r_prio_i;
`endif

  always_comb begin
    w_i_pend  = i_dfp_read | i_dfp_write;
    w_d_pend  = d_dfp_read | d_dfp_write;
`ifdef ARB_ROUND_ROBIN_EN
    w_grant_d = w_d_pend & (~w_i_pend | ~r_prio_i);
`else
    w_grant_d = w_d_pend;
`endif
    w_req_sel = '0;
    if (w_grant_d) begin
      w_req_sel.addr  = ARB_ADDR_W'(d_dfp_addr);
      w_req_sel.read  = d_dfp_read;
      w_req_sel.write = d_dfp_write;
      w_req_sel.wdata = ARB_LINE_W'(d_dfp_wdata);
    end else begin
      w_req_sel.addr  = ARB_ADDR_W'(i_dfp_addr);
      w_req_sel.read  = i_dfp_read;
      w_req_sel.write = i_dfp_write;
      w_req_sel.wdata = ARB_LINE_W'(i_dfp_wdata);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d)     w_next = SERVE_D;
        else if (w_i_pend) w_next = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (dfp_resp) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_enter = (r_state == IDLE) && (w_next != IDLE);

  // Request payload is data; outputs are qualified by r_state, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_enter) r_req <= w_req_sel;
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_prio_i <= 1'b1;
    else if (w_enter) r_prio_i <= (w_next == SERVE_D);
  end
`endif

  always_comb begin
    w_serving   = (r_state == SERVE_I) || (r_state == SERVE_D);
    dfp_read    = w_serving & r_req.read;
    dfp_write   = w_serving & r_req.write;
    dfp_addr    = r_req.addr[ADDR_W-1:0];
    dfp_wdata   = r_req.wdata[LINE_W-1:0];
    i_dfp_resp  = (r_state == SERVE_I) & dfp_resp;
    d_dfp_resp  = (r_state == SERVE_D) & dfp_resp;
    i_dfp_rdata = (r_state == SERVE_I) ? dfp_rdata : '0;
    d_dfp_rdata = (r_state == SERVE_D) ? dfp_rdata : '0;
  end

endmodule
